// File: rtl/fifo_ms_write_arbiter_if.sv
// Producer-side and FIFO-side handshake bundle for the multi-stream FIFO write arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface fifo_ms_write_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FLUX       = 2
);
   logic [FLUX-1:0]                     req_valid;
   logic [FLUX*DATA_WIDTH-1:0]          req_data;
   logic [FLUX-1:0]                     req_ready;
   logic [DATA_WIDTH+$clog2(FLUX)-1:0]  fifo_din;
   logic                                fifo_write;
   logic [FLUX-1:0]                     fifo_full;
   logic [FLUX-1:0]                     grant;
   logic                                busy;

   modport slave (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_din, fifo_write, grant, busy
   );

   modport master (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_din, fifo_write, grant, busy
   );
endinterface

// File: rtl/fifo_ms_write_arbiter.sv
// Round-robin write-port arbiter for fifo_ms: FLUX producers, bursts of up to BURST words,
// each word tagged with its flux id and gated by that stream's full flag.
module fifo_ms_write_arbiter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FLUX       = 2,
   parameter int unsigned BURST      = 4
) (
   input logic                    clk,
   input logic                    rst,
   fifo_ms_write_arbiter_if.slave bus
);
   localparam int unsigned IDW = $clog2(FLUX);
   localparam int unsigned CW  = $clog2(BURST + 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]      state, state_d;
   logic [IDW-1:0]  grant_id, grant_id_d;
   logic [IDW-1:0]  last_id, last_id_d;
   logic [CW-1:0]   burst_cnt, burst_cnt_d;

   logic [FLUX-1:0] elig;
   logic [IDW-1:0]  scan_base;
   logic [IDW-1:0]  pick_id;
   logic            found;
   logic            wr;
   logic            rel;
   int              idx;

   always_comb begin
      elig      = bus.req_valid & ~bus.fifo_full;
      wr        = (state == GRANT) && bus.req_valid[grant_id] && !bus.fifo_full[grant_id];
      rel       = (wr && (burst_cnt == CW'(BURST - 1))) || !bus.req_valid[grant_id] ||
                  bus.fifo_full[grant_id];
      // Releasing a grant updates last_id to grant_id, so both cases scan after one id.
      scan_base = (state == GRANT) ? grant_id : last_id;
      found     = 1'b0;
      pick_id   = '0;
      idx       = 0;
      // Descending offset so the nearest eligible id after scan_base wins.
      for (int k = int'(FLUX); k >= 1; k--) begin
         idx = (int'(scan_base) + k) % int'(FLUX);
         if (elig[idx]) begin
            found   = 1'b1;
            pick_id = IDW'(idx);
         end
      end
   end

   always_comb begin
      state_d     = state;
      grant_id_d  = grant_id;
      last_id_d   = last_id;
      burst_cnt_d = burst_cnt;
      if (state == IDLE) begin
         if (found) begin
            state_d     = GRANT;
            grant_id_d  = pick_id;
            burst_cnt_d = '0;
         end
      end else begin
         if (rel) begin
            last_id_d   = grant_id;
            burst_cnt_d = '0;
            if (found) begin
               grant_id_d = pick_id;
            end else begin
               state_d = IDLE;
            end
         end else if (wr) begin
            burst_cnt_d = burst_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grant_id  <= '0;
         last_id   <= IDW'(FLUX - 1);
         burst_cnt <= '0;
      end else begin
         state     <= state_d;
         grant_id  <= grant_id_d;
         last_id   <= last_id_d;
         burst_cnt <= burst_cnt_d;
      end
   end

   always_comb begin
      bus.fifo_write = wr;
      bus.busy       = (state == GRANT);
      bus.req_ready  = wr ? (FLUX'(1) << grant_id) : '0;
      bus.grant      = (state == GRANT) ? (FLUX'(1) << grant_id) : '0;
      bus.fifo_din   = (state == GRANT) ?
                       {grant_id, bus.req_data[grant_id*DATA_WIDTH +: DATA_WIDTH]} : '0;
   end
endmodule

// File: tb/tb_fifo_ms_write_arbiter.sv
// Randomised scoreboard bench for fifo_ms_write_arbiter against a cycle-level reference model.
module tb_fifo_ms_write_arbiter;
   localparam int unsigned DW    = 8;
   localparam int unsigned FLUX  = 2;
   localparam int unsigned BURST = 4;
   localparam int unsigned IDW   = $clog2(FLUX);
   localparam int unsigned DINW  = DW + IDW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_ms_write_arbiter_if #(.DATA_WIDTH(DW), .FLUX(FLUX)) bus ();

   fifo_ms_write_arbiter #(.DATA_WIDTH(DW), .FLUX(FLUX), .BURST(BURST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic            wr;
      logic [FLUX-1:0] ready;
      logic [FLUX-1:0] grant;
      logic            busy;
   } stat_t;

   stat_t           sq[$];
   logic [DINW-1:0] wq[$];
   int              checks   = 0;
   int              failures = 0;
   bit              mon_en   = 1'b0;

   // Model registers: in_grant, owner id, last served id, words written in current grant.
   int m_st, m_gid, m_last, m_cnt;

   function automatic int pick_after(int base, logic [FLUX-1:0] e);
      for (int off = 1; off <= int'(FLUX); off++) begin
         int id = (base + off) % int'(FLUX);
         if (e[id]) return id;
      end
      return -1;
   endfunction

   function automatic logic [FLUX-1:0] rbits(int pct);
      logic [FLUX-1:0] r = '0;
      for (int i = 0; i < int'(FLUX); i++) r[i] = ($urandom_range(99) < pct);
      return r;
   endfunction

   task automatic model_reset();
      m_st   = 0;
      m_gid  = 0;
      m_last = FLUX - 1;
      m_cnt  = 0;
   endtask

   task automatic drive_cycle(input logic [FLUX-1:0] v, input logic [FLUX-1:0] f);
      stat_t           s;
      logic [FLUX-1:0] e;
      bit              w, done;
      int              p;
      @(posedge clk);
      #1;
      bus.req_valid = v;
      bus.fifo_full = f;
      for (int i = 0; i < int'(FLUX); i++) bus.req_data[i*DW +: DW] = DW'($urandom);
      e       = v & ~f;
      w       = (m_st == 1) && v[m_gid] && !f[m_gid];
      s.wr    = w;
      s.busy  = (m_st == 1);
      s.grant = s.busy ? (FLUX'(1) << m_gid) : '0;
      s.ready = w ? (FLUX'(1) << m_gid) : '0;
      sq.push_back(s);
      if (w) wq.push_back({IDW'(m_gid), bus.req_data[m_gid*DW +: DW]});
      mon_en = 1'b1;
      if (m_st == 0) begin
         p = pick_after(m_last, e);
         if (p >= 0) begin
            m_st  = 1;
            m_gid = p;
            m_cnt = 0;
         end
      end else begin
         if (w) m_cnt++;
         done = (w && m_cnt == int'(BURST)) || !v[m_gid] || f[m_gid];
         if (done) begin
            m_last = m_gid;
            p      = pick_after(m_gid, e);
            if (p >= 0) begin
               m_gid = p;
               m_cnt = 0;
            end else begin
               m_st = 0;
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      stat_t           s;
      logic [DINW-1:0] w;
      if (mon_en && sq.size() > 0) begin
         s = sq.pop_front();
         checks++;
         if (bus.fifo_write !== s.wr || bus.grant !== s.grant || bus.busy !== s.busy ||
             bus.req_ready !== s.ready) begin
            failures++;
            $display("FAIL status t=%0t wr=%b/%b grant=%b/%b busy=%b/%b ready=%b/%b (got/want)",
                     $time, bus.fifo_write, s.wr, bus.grant, s.grant, bus.busy, s.busy,
                     bus.req_ready, s.ready);
         end
         if (!s.busy) begin
            checks++;
            if (bus.fifo_din !== '0) begin
               failures++;
               $display("FAIL idle_din t=%0t got=%0h want=0", $time, bus.fifo_din);
            end
         end
         if (bus.fifo_write === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write t=%0t din=%0h", $time, bus.fifo_din);
            end else begin
               w = wq.pop_front();
               if (bus.fifo_din !== w) begin
                  failures++;
                  $display("FAIL write_din t=%0t got=%0h want=%0h", $time, bus.fifo_din, w);
               end
            end
         end else if (s.wr && wq.size() > 0) begin
            void'(wq.pop_front());
         end
      end
   end

   initial begin
      bit reached;
      int pv[4] = '{90, 60, 95, 30};
      int pf[4] = '{0, 10, 40, 20};
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.fifo_full = '0;
      bus.req_data  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      bus.req_valid = '1;
      #2;
      chk("rst_write", 32'(bus.fifo_write), 0);
      chk("rst_grant", 32'(bus.grant), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_din", 32'(bus.fifo_din), 0);
      bus.req_valid = '0;
      @(posedge clk);
      #1 rst = 1'b0;

      // Single producer, back-to-back bursts.
      repeat (12) drive_cycle(2'b01, 2'b00);
      // Both producers, round-robin bursts.
      repeat (20) drive_cycle(2'b11, 2'b00);
      repeat (3) drive_cycle(2'b00, 2'b00);
      // Stream 0 fills mid-burst.
      repeat (3) drive_cycle(2'b11, 2'b00);
      repeat (6) drive_cycle(2'b11, 2'b01);
      repeat (4) drive_cycle(2'b11, 2'b00);
      repeat (3) drive_cycle(2'b00, 2'b00);
      // Producer 1 drops valid after one write.
      repeat (2) drive_cycle(2'b10, 2'b00);
      repeat (3) drive_cycle(2'b00, 2'b00);
      // Both streams full, then stream 1 frees up.
      repeat (4) drive_cycle(2'b11, 2'b11);
      repeat (4) drive_cycle(2'b11, 2'b01);

      for (int ph = 0; ph < 4; ph++) begin
         for (int n = 0; n < 500; n++) drive_cycle(rbits(pv[ph]), rbits(pf[ph]));
      end

      // Reset on the third write of a burst.
      reached = 1'b0;
      for (int n = 0; n < 40 && !reached; n++) begin
         drive_cycle(2'b11, 2'b00);
         reached = (m_st == 1) && (m_cnt == 2);
      end
      chk("burst_reached", 32'(reached), 1);
      drive_cycle(2'b11, 2'b00);
      #1;
      chk("pre_rst_write", 32'(bus.fifo_write), 1);
      rst    = 1'b1;
      mon_en = 1'b0;
      #1;
      chk("midrst_write", 32'(bus.fifo_write), 0);
      chk("midrst_grant", 32'(bus.grant), 0);
      chk("midrst_busy", 32'(bus.busy), 0);
      sq.delete();
      wq.delete();
      repeat (2) @(posedge clk);
      #1;
      bus.req_valid = '0;
      bus.fifo_full = '0;
      rst           = 1'b0;
      model_reset();
      drive_cycle(2'b11, 2'b00);
      drive_cycle(2'b11, 2'b00);
      #1;
      chk("post_rst_grant", 32'(bus.grant), 32'h1);
      repeat (10) drive_cycle(2'b11, 2'b00);
      repeat (2) drive_cycle(2'b00, 2'b00);
      @(negedge clk);
      #1;
      chk("status_q_drained", 32'(sq.size()), 0);
      chk("write_q_drained", 32'(wq.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_ms_write_arbiter.md
Name: fifo_ms_write_arbiter

Overview:
- Round-robin write-side arbiter for the multi-stream FIFO (fifo_ms).
- FLUX independent producers share the FIFO's single write port.
- Each word is tagged with its flux id, and the arbiter honours the per-flux full flags.
- A granted producer holds the port for up to BURST consecutive writes, then the grant rotates.

Parameters:
- DATA_WIDTH, 8, payload width per producer.
- FLUX, 2, number of producers / FIFO streams; must be >= 2.
- BURST, 4, max consecutive writes per grant; must be >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  FLUX  per-producer data valid.
- req_data  input  FLUX*DATA_WIDTH  producer payloads; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  FLUX  per-producer accept; word i is consumed when req_valid[i] and req_ready[i] are both high.
- fifo_din  output  DATA_WIDTH+$clog2(FLUX)  to FIFO din; {flux id in MSBs, payload in LSBs}.
- fifo_write  output  1  to FIFO write.
- fifo_full  input  FLUX  from FIFO full, per stream.
- grant  output  FLUX  one-hot current grant; zero when idle.
- busy  output  1  high in GRANT state.

Behaviour:
- Eligibility: elig[i] = req_valid[i] & ~fifo_full[i].
- Pick function: first set bit of elig, scanning from (last_id+1) mod FLUX upward with wrap.
  - The scan may return last_id itself if it is the only eligible producer.
- Registers and reset values:
  - state = IDLE
  - grant_id = 0
  - last_id = FLUX-1, so the first pick favours id 0
  - burst_cnt = 0
- Output values while rst is high: fifo_write=0, req_ready=0, grant=0, busy=0, fifo_din=0.
- Combinational outputs:
  - wr = (state==GRANT) & req_valid[grant_id] & ~fifo_full[grant_id].
  - fifo_write = wr.
  - req_ready[i] = wr & (i==grant_id).
  - fifo_din = {grant_id, req_data[grant_id]} in GRANT, 0 in IDLE.
  - grant = onehot(grant_id) in GRANT, 0 in IDLE.
  - There is no registered latency on the write path; fifo_full to fifo_write is a combinational path.
- IDLE state:
  - No writes occur.
  - If any elig bit is set: grant_id <= pick, burst_cnt <= 0, go to GRANT.
  - Latency from first valid to first write is 1 cycle.
- GRANT state:
  - On wr, burst_cnt increments.
  - The grant is released at the clock edge when any of the following holds:
    - wr & burst_cnt==BURST-1 (burst exhausted)
    - ~req_valid[grant_id] (producer dropped valid)
    - fifo_full[grant_id] (stream full, no write this cycle)
  - On release: last_id <= grant_id.
    - If another pick exists, computed from the current elig with the scan starting at grant_id+1, then grant_id <= that pick, burst_cnt <= 0, and state stays GRANT. There is no bubble between grants.
    - Otherwise go to IDLE.
  - Hold (no release): grant_id and last_id are unchanged.
- Simultaneous events:
  - A write on the final burst beat and a switch to the next grant happen in the same cycle.
  - Full asserting mid-burst releases the grant without writing; that stream is skipped until full drops.
- Single active producer: it regains the grant immediately after each burst, giving back-to-back bursts with no idle cycle.
- Fairness: with all producers continuously eligible, the service order is 0,1,...,FLUX-1,0,... with exactly BURST words each.
- burst_cnt width is $clog2(BURST+1). burst_cnt never exceeds BURST-1 while in GRANT.
- Reset asserted mid-burst: all registers return to their reset values immediately (asynchronous reset), and fifo_write drops in the same cycle. No partial word is written after rst rises.
- Out-of-range grant_id is unreachable; for non-power-of-2 FLUX, the pick wraps modulo FLUX.

Test Plan (DATA_WIDTH=8, FLUX=2, BURST=4):
- Reset, then valid=2'b01 with data0 = 0x10..0x13 incrementing on each accept → IDLE for 1 cycle, then fifo_din = 0x010, 0x011, 0x012, 0x013 on 4 consecutive cycles. grant=01. The next burst starts the following cycle with no IDLE gap.
- Both producers valid continuously, data0=0xA0+n, data1=0xB0+n → writes 0x0A0–0x0A3, then 0x1B0–0x1B3, then 0x0A4…; fifo_write stays high with no gaps.
- Producer 0 granted, fifo_full=2'b01 asserted after its 2nd write, producer 1 valid → 2 writes tagged 0, then grant switches to 1 on the next cycle. Producer 0 is skipped until full[0] drops.
- Producer 1 drops valid after 1 write while producer 0 is idle → 1 write 0x1xx, then IDLE, busy=0, grant=00.
- Both fifo_full bits high with both producers valid → fifo_write stays 0, state stays IDLE. Releasing full[1] → grant=10 next cycle, and the first write is tagged 1.
- Assert rst during the 3rd write of a burst → fifo_write=0 the same cycle, grant=00. After release, with both producers valid, producer 0 is granted first.
